// File: rtl/algo_1rnw_pkg.sv
// Shared types and constants for the 1RnW live-value-table memory.
package algo_1rnw_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned rd_latency(input int unsigned flopin,
                                               input int unsigned sram_delay,
                                               input int unsigned flopout);
        return flopin + sram_delay + flopout;
    endfunction

endpackage

// File: rtl/algo_1rnw_lvt.sv
// Live-value table: per address, the index of the port that wrote it last.
// Also flags same-cycle writes from different ports to one address.
module algo_1rnw_lvt
    import algo_1rnw_pkg::*;
#(
    parameter int unsigned NUMADDR = 8192,
    parameter int unsigned BITADDR = 13,
    parameter int unsigned NUMWRPT = 2,
    parameter int unsigned BITWRPT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMWRPT-1:0]         i_wr,
    input  logic [NUMWRPT*BITADDR-1:0] i_wadr,
    input  logic [BITADDR-1:0]         i_radr,
    output logic [BITWRPT-1:0]         o_rsel_c,
    output logic                       o_coll
);

    localparam int unsigned LVT_AW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;

    logic [BITWRPT-1:0] r_lvt [NUMADDR];
    logic               r_coll;
    logic               w_coll;

    // Ports are applied in ascending order so the highest index wins a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned a = 0; a < NUMADDR; a++) begin
                r_lvt[a] <= '0;
            end
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_coll;
            for (int unsigned i = 0; i < NUMWRPT; i++) begin
                if (i_wr[i]) begin
                    r_lvt[LVT_AW'(i_wadr[i*BITADDR +: BITADDR])] <= BITWRPT'(i);
                end
            end
        end
    end

    always_comb begin
        w_coll = 1'b0;
        for (int unsigned i = 0; i < NUMWRPT; i++) begin
            for (int unsigned j = i + 1; j < NUMWRPT; j++) begin
                if (i_wr[i] && i_wr[j] &&
                    (i_wadr[i*BITADDR +: BITADDR] == i_wadr[j*BITADDR +: BITADDR])) begin
                    w_coll = 1'b1;
                end
            end
        end
    end

    assign o_rsel_c = r_lvt[LVT_AW'(i_radr)];
    assign o_coll   = r_coll;

endmodule

// File: rtl/algo_1rnw_lvt_top_wrap.sv
// Wrapper mapping IP_/T1_ parameter names onto algo_1rnw_lvt_top.
module algo_1rnw_lvt_top_wrap #(
    parameter int unsigned IP_WIDTH   = 32,
    parameter int unsigned IP_NUMADDR = 8192,
    parameter int unsigned IP_BITADDR = 13,
    parameter int unsigned IP_NUMWRPT = 2,
    parameter int unsigned IP_BITWRPT = 1,
    parameter int unsigned T1_DELAY   = 1,
    parameter int unsigned FLOPIN     = 0,
    parameter int unsigned FLOPOUT    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ready,
    input  logic [IP_NUMWRPT-1:0]            write,
    input  logic [IP_NUMWRPT*IP_BITADDR-1:0] wr_adr,
    input  logic [IP_NUMWRPT*IP_WIDTH-1:0]   din,
    input  logic                             read,
    input  logic [IP_BITADDR-1:0]            rd_adr,
    output logic                             rd_vld,
    output logic [IP_WIDTH-1:0]              rd_dout,
    output logic                             wr_coll,
    output logic [IP_NUMWRPT-1:0]            t1_writeA,
    output logic [IP_NUMWRPT*IP_BITADDR-1:0] t1_addrA,
    output logic [IP_NUMWRPT*IP_WIDTH-1:0]   t1_dinA,
    output logic [IP_NUMWRPT*IP_WIDTH-1:0]   t1_bwA,
    output logic [IP_NUMWRPT-1:0]            t1_readB,
    output logic [IP_NUMWRPT*IP_BITADDR-1:0] t1_addrB,
    input  logic [IP_NUMWRPT*IP_WIDTH-1:0]   t1_doutB
);

    algo_1rnw_lvt_top #(
        .WIDTH      (IP_WIDTH),
        .NUMADDR    (IP_NUMADDR),
        .BITADDR    (IP_BITADDR),
        .NUMWRPT    (IP_NUMWRPT),
        .BITWRPT    (IP_BITWRPT),
        .SRAM_DELAY (T1_DELAY),
        .FLOPIN     (FLOPIN),
        .FLOPOUT    (FLOPOUT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .write     (write),
        .wr_adr    (wr_adr),
        .din       (din),
        .read      (read),
        .rd_adr    (rd_adr),
        .rd_vld    (rd_vld),
        .rd_dout   (rd_dout),
        .wr_coll   (wr_coll),
        .t1_writeA (t1_writeA),
        .t1_addrA  (t1_addrA),
        .t1_dinA   (t1_dinA),
        .t1_bwA    (t1_bwA),
        .t1_readB  (t1_readB),
        .t1_addrB  (t1_addrB),
        .t1_doutB  (t1_doutB)
    );

endmodule

// File: rtl/algo_1rnw_lvt_top.sv
// One-read, NUMWRPT-write memory built from one 1R1W bank per write port;
// the live-value table picks which bank holds the current word.
module algo_1rnw_lvt_top
    import algo_1rnw_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUMADDR    = 8192,
    parameter int unsigned BITADDR    = 13,
    parameter int unsigned NUMWRPT    = 2,
    parameter int unsigned BITWRPT    = 1,
    parameter int unsigned SRAM_DELAY = 1,
    parameter int unsigned FLOPIN     = 0,
    parameter int unsigned FLOPOUT    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUMWRPT-1:0]         write,
    input  logic [NUMWRPT*BITADDR-1:0] wr_adr,
    input  logic [NUMWRPT*WIDTH-1:0]   din,
    input  logic                       read,
    input  logic [BITADDR-1:0]         rd_adr,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dout,
    output logic                       wr_coll,
    output logic [NUMWRPT-1:0]         t1_writeA,
    output logic [NUMWRPT*BITADDR-1:0] t1_addrA,
    output logic [NUMWRPT*WIDTH-1:0]   t1_dinA,
    output logic [NUMWRPT*WIDTH-1:0]   t1_bwA,
    output logic [NUMWRPT-1:0]         t1_readB,
    output logic [NUMWRPT*BITADDR-1:0] t1_addrB,
    input  logic [NUMWRPT*WIDTH-1:0]   t1_doutB
);

    localparam int unsigned      PIPE_D  = rd_latency(0, SRAM_DELAY, 0);
    localparam logic [BITADDR:0] ADR_LIM = (BITADDR+1)'(NUMADDR);
    localparam logic [BITADDR-1:0] ADR_LAST = BITADDR'(NUMADDR - 1);

    state_e               r_state;
    logic [BITADDR-1:0]   r_init_adr;
    logic                 r_init_we;
    logic                 r_ready;

    logic [NUMWRPT-1:0]         w_wr_q, w_wr;
    logic [NUMWRPT*BITADDR-1:0] w_wadr;
    logic [NUMWRPT*WIDTH-1:0]   w_din;
    logic                       w_rd_q, w_rd;
    logic [BITADDR-1:0]         w_radr;
    logic [BITWRPT-1:0]         w_rsel;
    logic                       w_pipe_vld;
    logic [BITWRPT-1:0]         w_pipe_sel;
    logic [WIDTH-1:0]           w_bank_dout;

    logic                 r_vld_pipe [PIPE_D];
    logic [BITWRPT-1:0]   r_sel_pipe [PIPE_D];

    // INIT zeroes every bank one address per cycle, then hands over to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_init_adr <= '0;
            r_init_we  <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_we <= 1'b1;
                    if (r_init_we) begin
                        if (r_init_adr == ADR_LAST) begin
                            r_state   <= ST_RUN;
                            r_init_we <= 1'b0;
                            r_ready   <= 1'b1;
                        end else begin
                            r_init_adr <= r_init_adr + 1'b1;
                        end
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        w_wr_q = '0;
        for (int unsigned i = 0; i < NUMWRPT; i++) begin
            w_wr_q[i] = write[i] & r_ready &
                        ({1'b0, wr_adr[i*BITADDR +: BITADDR]} < ADR_LIM);
        end
    end

    assign w_rd_q = read & r_ready & ({1'b0, rd_adr} < ADR_LIM);

    generate
        if (FLOPIN != 0) begin : g_flopin
            logic [NUMWRPT-1:0]         r_in_wr;
            logic [NUMWRPT*BITADDR-1:0] r_in_wadr;
            logic [NUMWRPT*WIDTH-1:0]   r_in_din;
            logic                       r_in_rd;
            logic [BITADDR-1:0]         r_in_radr;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_in_wr   <= '0;
                    r_in_wadr <= '0;
                    r_in_din  <= '0;
                    r_in_rd   <= 1'b0;
                    r_in_radr <= '0;
                end else begin
                    r_in_wr   <= w_wr_q;
                    r_in_wadr <= wr_adr;
                    r_in_din  <= din;
                    r_in_rd   <= w_rd_q;
                    r_in_radr <= rd_adr;
                end
            end

            assign w_wr   = r_in_wr;
            assign w_wadr = r_in_wadr;
            assign w_din  = r_in_din;
            assign w_rd   = r_in_rd;
            assign w_radr = r_in_radr;
        end else begin : g_direct
            assign w_wr   = w_wr_q;
            assign w_wadr = wr_adr;
            assign w_din  = din;
            assign w_rd   = w_rd_q;
            assign w_radr = rd_adr;
        end
    endgenerate

    assign t1_writeA = r_init_we ? {NUMWRPT{1'b1}}       : w_wr;
    assign t1_addrA  = r_init_we ? {NUMWRPT{r_init_adr}} : w_wadr;
    assign t1_dinA   = r_init_we ? '0                    : w_din;
    assign t1_bwA    = '1;
    assign t1_readB  = {NUMWRPT{w_rd}};
    assign t1_addrB  = {NUMWRPT{w_radr}};

    algo_1rnw_lvt #(
        .NUMADDR (NUMADDR),
        .BITADDR (BITADDR),
        .NUMWRPT (NUMWRPT),
        .BITWRPT (BITWRPT)
    ) u_lvt (
        .clk      (clk),
        .rst      (rst),
        .i_wr     (w_wr),
        .i_wadr   (w_wadr),
        .i_radr   (w_radr),
        .o_rsel_c (w_rsel),
        .o_coll   (wr_coll)
    );

    // Bank select travels alongside the SRAM access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < PIPE_D; k++) begin
                r_vld_pipe[k] <= 1'b0;
                r_sel_pipe[k] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_rd;
            r_sel_pipe[0] <= w_rsel;
            for (int unsigned k = 1; k < PIPE_D; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_sel_pipe[k] <= r_sel_pipe[k-1];
            end
        end
    end

    assign w_pipe_vld = r_vld_pipe[PIPE_D-1];
    assign w_pipe_sel = r_sel_pipe[PIPE_D-1];

    always_comb begin
        w_bank_dout = '0;
        for (int unsigned i = 0; i < NUMWRPT; i++) begin
            if (w_pipe_sel == BITWRPT'(i)) begin
                w_bank_dout = t1_doutB[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        if (FLOPOUT != 0) begin : g_flopout
            logic             r_out_vld;
            logic [WIDTH-1:0] r_out_dout;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_out_vld  <= 1'b0;
                    r_out_dout <= '0;
                end else begin
                    r_out_vld <= w_pipe_vld;
                    if (w_pipe_vld) begin
                        r_out_dout <= w_bank_dout;
                    end
                end
            end

            assign rd_vld  = r_out_vld;
            assign rd_dout = r_out_dout;
        end else begin : g_outdirect
            logic [WIDTH-1:0] r_hold;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_hold <= '0;
                end else if (w_pipe_vld) begin
                    r_hold <= w_bank_dout;
                end
            end

            assign rd_vld  = w_pipe_vld;
            assign rd_dout = w_pipe_vld ? w_bank_dout : r_hold;
        end
    endgenerate

    assign ready = r_ready;

endmodule

// File: doc/algo_1rnw_lvt_top.md
ALGO_1RNW_LVT_TOP -- requirements
Module: algo_1rnw_lvt_top

Interface
REQ-001 Parameter WIDTH, 32, data bits per word.
REQ-002 Parameter NUMADDR, 8192, logical words; BITADDR, 13, address bits (NUMADDR <= 2**BITADDR).
REQ-003 Parameter NUMWRPT, 2, write ports (2..8); BITWRPT, 1, ceil(log2(NUMWRPT)).
REQ-004 Parameter SRAM_DELAY, 1, bank read latency in cycles (1..3).
REQ-005 Parameter FLOPIN, 0, input register stage (0/1); FLOPOUT, 0, output register stage (0/1).
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst  in  1  reset; asynchronous, active-low.
REQ-008 ready  out  1  high once initialisation completes.
REQ-009 write  in  NUMWRPT  per-port write enable; wr_adr in NUMWRPT*BITADDR; din in NUMWRPT*WIDTH; port i at slice i.
REQ-010 read  in  1  read enable; rd_adr in BITADDR.
REQ-011 rd_vld  out  1  read data valid; rd_dout out WIDTH read data.
REQ-012 wr_coll  out  1  pulse: two or more accepted writes to one address in the same cycle.
REQ-013 t1_writeA out NUMWRPT; t1_addrA out NUMWRPT*BITADDR; t1_dinA out NUMWRPT*WIDTH; t1_bwA out NUMWRPT*WIDTH, tied all-ones.
REQ-014 t1_readB out NUMWRPT; t1_addrB out NUMWRPT*BITADDR; t1_doutB in NUMWRPT*WIDTH; bank i is a 1R1W SRAM, NUMADDR deep.

Function
REQ-015 Bank i SHALL be written only by write port i; every bank SHALL be read at rd_adr on each accepted read.
REQ-016 A live-value table (LVT), NUMADDR x BITWRPT flops, SHALL record per address the index of the last port to write it.
REQ-017 Accepted read: LVT entry sampled in the read cycle, delayed SRAM_DELAY cycles, SHALL select which bank's t1_doutB drives rd_dout.
REQ-018 Read latency from read to rd_vld SHALL be FLOPIN+SRAM_DELAY+FLOPOUT cycles exactly; one read per cycle, fully pipelined.
REQ-019 Simultaneous writes to one address: all such banks SHALL be written, LVT SHALL take the highest port index, wr_coll SHALL pulse one cycle later.
REQ-020 Read and write to one address in the same cycle SHALL return the pre-write data (LVT update visible next cycle).
REQ-021 rd_dout SHALL hold its last value when rd_vld is low.
REQ-022 write/read while ready=0 SHALL be ignored: no bank access, no LVT update, no rd_vld.
REQ-023 Addresses >= NUMADDR SHALL be ignored as in REQ-022.

Reset
REQ-024 On rst low: ready=0, rd_vld=0, rd_dout=0, wr_coll=0, all t1 enables 0, LVT all zero, read pipeline flushed.
REQ-025 FSM states: INIT, RUN. Reset enters INIT; INIT drives t1_writeA all-ones, t1_dinA zero, sweeping address 0..NUMADDR-1 one per cycle.
REQ-026 INIT->RUN after address NUMADDR-1 is written; ready SHALL rise the following cycle (NUMADDR+1 cycles after reset release).
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abort in-flight reads (no rd_vld) and restart INIT from address 0.

Structure
REQ-028 Shared package algo_1rnw_pkg SHALL hold FSM state typedef and the latency constant function.
REQ-029 One sub-module, algo_1rnw_lvt, SHALL contain the LVT array, its write-priority logic, and collision detect.
REQ-030 A wrapper algo_1rnw_lvt_top_wrap SHALL map IP_/T1_ parameters onto this module, as with existing wraps.

Verification (NUMWRPT=2, WIDTH=32, NUMADDR=16, SRAM_DELAY=1, FLOPIN=FLOPOUT=0)
REQ-031 Release reset -> ready=0 for 16 cycles, ready=1 at cycle 17; read addr 5 -> rd_dout=0x0, rd_vld one cycle later.
REQ-032 Port0 writes 0xAAAA0001 to addr 3, next cycle port1 writes 0xBBBB0002 to addr 3; read addr 3 -> 0xBBBB0002.
REQ-033 Both ports write addr 7 same cycle (0x11, 0x22) -> wr_coll pulses next cycle; read addr 7 -> 0x22.
REQ-034 Addr 9 holds 0x5; same cycle port0 writes 0x6 to addr 9 and read addr 9 -> 0x5; following read -> 0x6.
REQ-035 Back-to-back reads addr 0..15 after random writes -> 16 consecutive rd_vld cycles matching model; reset asserted mid-stream -> rd_vld drops immediately, ready returns after 17 cycles.
